// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter
// ----------------------------------------------------------------------------
// Two-port round-robin arbiter and access sequencer for the single-port data
// memory. Port 0 is the core load/store unit, port 1 the debug/DMA master.
// Each accepted request is latched, issued to the memory as exactly one access
// cycle, and answered with a one-cycle response pulse. Misaligned requests are
// rejected locally with err=1 and never reach the memory.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pN_req/we/addr/rw_type   request side of port N (N = 0, 1)
//   pN_wdata                 store data of port N
//   pN_gnt                   combinational grant, accepted on this edge
//   pN_rvalid/rdata/err      one-cycle response of port N
//   mem_W_en, mem_R_en       memory strobes (only in the access cycle)
//   mem_addr/RW_type/din     latched access attributes towards the memory
//   mem_dout, mem_error      combinational memory read data and error flag
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [31:0]           p0_addr,
    input  logic [2:0]            p0_rw_type,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [31:0]           p1_addr,
    input  logic [2:0]            p1_rw_type,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,

    output logic                  mem_W_en,
    output logic                  mem_R_en,
    output logic [31:0]           mem_addr,
    output logic [2:0]            mem_RW_type,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_error
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                state;
    logic                  last;      // port granted most recently
    logic                  owner;     // port owning the outstanding access
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [2:0]            type_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    // Request selected by the grant logic this cycle
    logic                  sel_we;
    logic [31:0]           sel_addr;
    logic [2:0]            sel_type;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_misaligned;
    logic                  can_grant;

    // ------------------------------------------------------------------------
    // Grant: only in IDLE and never while reset is asserted. On contention the
    // port that was not granted last wins; a lone requester always wins.
    // ------------------------------------------------------------------------
    assign can_grant = (state == IDLE) && !rst;
    assign p0_gnt    = can_grant && p0_req && (!p1_req || last);
    assign p1_gnt    = can_grant && p1_req && (!p0_req || !last);

    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_type  = p0_rw_type;
        sel_wdata = p0_wdata;
        if (p1_gnt) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_type  = p1_rw_type;
            sel_wdata = p1_wdata;
        end
    end

    // The memory does no alignment checking, so it is enforced here
    always_comb begin
        sel_misaligned = 1'b0;
        case (sel_type[1:0])
            2'b00:   sel_misaligned = 1'b0;
            2'b01:   sel_misaligned = sel_addr[0];
            default: sel_misaligned = (sel_addr[1:0] != 2'b00);
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            type_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_gnt || p1_gnt) begin
                        owner   <= p1_gnt;
                        last    <= p1_gnt;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        type_q  <= sel_type;
                        wdata_q <= sel_wdata;
                        rdata_q <= '0;
                        if (sel_misaligned) begin
                            // Answer directly without touching the memory
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    rdata_q <= (!we_q && !mem_error) ? mem_dout : '0;
                    err_q   <= mem_error;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Memory side: attributes hold their latched values; strobes only in
    // ACCESS. The write strobe is additionally gated by reset so a reset in
    // the access cycle cannot commit a store.
    // ------------------------------------------------------------------------
    assign mem_addr    = addr_q;
    assign mem_RW_type = type_q;
    assign mem_din     = wdata_q;
    assign mem_W_en    = (state == ACCESS) && we_q && !rst;
    assign mem_R_en    = (state == ACCESS) && !we_q;

    // ------------------------------------------------------------------------
    // Response side: decoded from registered state, so only the owner sees a
    // pulse and the other port stays at 0.
    // ------------------------------------------------------------------------
    assign p0_rvalid = (state == RESP) && !owner;
    assign p1_rvalid = (state == RESP) && owner;
    assign p0_rdata  = p0_rvalid ? rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? rdata_q : '0;
    assign p0_err    = p0_rvalid && err_q;
    assign p1_err    = p1_rvalid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter
// ----------------------------------------------------------------------------
// Directed bench for dmem_arbiter. A small little-endian byte memory
// (256 bytes, error for addresses at or above 0x100) stands in for the data
// memory. Each step drives a request, waits (bounded) for the grant and the
// response, and checks latency, data, error flag and strobe counts against
// hand-computed values.
// ============================================================================
module tb_dmem_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [31:0]   p0_addr, p1_addr;
    logic [2:0]    p0_rw_type, p1_rw_type;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_W_en, mem_R_en, mem_error;
    logic [31:0]   mem_addr;
    logic [2:0]    mem_RW_type;
    logic [DW-1:0] mem_din, mem_dout;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_rw_type(p0_rw_type), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_rw_type(p1_rw_type), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
        .mem_RW_type(mem_RW_type), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_error(mem_error)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [0:255];
    logic [7:0] a0, a1, a2, a3;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    always_comb begin
        a0 = mem_addr[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        mem_error = (mem_addr > 32'h0000_00FF);
        mem_dout  = '0;
        case (mem_RW_type[1:0])
            2'b00:   mem_dout = mem_RW_type[2] ? {24'h0, mem[a0]}
                                               : {{24{mem[a0][7]}}, mem[a0]};
            2'b01:   mem_dout = mem_RW_type[2] ? {16'h0, mem[a1], mem[a0]}
                                               : {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            default: mem_dout = {mem[a3], mem[a2], mem[a1], mem[a0]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_W_en && !mem_error) begin
            mem[a0] <= mem_din[7:0];
            if (mem_RW_type[1:0] != 2'b00) mem[a1] <= mem_din[15:8];
            if (mem_RW_type[1] == 1'b1) begin
                mem[a2] <= mem_din[23:16];
                mem[a3] <= mem_din[31:24];
            end
        end
        if (mem_W_en) wr_cnt <= wr_cnt + 1;
        if (mem_R_en) rd_cnt <= rd_cnt + 1;
        if (mem_W_en && mem_R_en) overlap <= overlap + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [2:0] typ,
                         input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_rw_type = typ; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_rw_type = typ; p1_wdata = wdata;
        end
    endtask

    // One complete transaction on one port; exp_lat is 2 (aligned) or 1 (misaligned)
    task automatic access(input string tag, input int port, input logic we,
                          input logic [31:0] addr, input logic [2:0] typ,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat);
        int  n;
        int  wr0, rd0;
        logic gnt, rv;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        drive(port, 1'b1, we, addr, typ, wdata);
        n = 0;
        #1;
        gnt = (port == 0) ? p0_gnt : p1_gnt;
        while (!gnt && n < 20) begin
            @(negedge clk); #1;
            gnt = (port == 0) ? p0_gnt : p1_gnt;
            n++;
        end
        check({tag, "_gnt"}, {31'b0, gnt}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(port, 1'b0, 1'b0, 32'h0, 3'b0, 32'h0);
        #1;
        n = 1;
        rv = (port == 0) ? p0_rvalid : p1_rvalid;
        while (!rv && n < 10) begin
            @(negedge clk); #1;
            rv = (port == 0) ? p0_rvalid : p1_rvalid;
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_rdata"}, (port == 0) ? p0_rdata : p1_rdata, exp_rdata);
        check({tag, "_err"}, {31'b0, (port == 0) ? p0_err : p1_err}, {31'b0, exp_err});
        check({tag, "_other_rv"}, {31'b0, (port == 0) ? p1_rvalid : p0_rvalid}, 32'd0);
        check({tag, "_wr_strobes"}, wr_cnt - wr0, (exp_lat == 2 && we) ? 1 : 0);
        check({tag, "_rd_strobes"}, rd_cnt - rd0, (exp_lat == 2 && !we) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, {30'b0, p1_gnt, p0_gnt}, 32'd0);
        check({tag, "_rvalid"}, {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
        check({tag, "_rdata"}, p0_rdata | p1_rdata, 32'd0);
        check({tag, "_err"}, {30'b0, p1_err, p0_err}, 32'd0);
        check({tag, "_strobes"}, {30'b0, mem_W_en, mem_R_en}, 32'd0);
        check({tag, "_mem_attr"}, mem_addr | mem_din | {29'b0, mem_RW_type}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    int order [6];
    int g, r, dual, rv_port;
    logic [31:0] exp_rd;

    initial begin
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0);   // request held during reset
        drive(1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("reset");
        drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        check_all_zero("idle");

        // store then load back through port 0
        access("st_word", 0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        access("ld_word", 0, 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        access("ld_byte_s", 0, 1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
        access("ld_half_u", 0, 1'b0, 32'h12, 3'b101, 32'h0, 32'h0000DEAD, 1'b0, 2);

        // misaligned requests on port 1 never reach memory
        access("mis_word", 1, 1'b0, 32'h02, 3'b010, 32'h0, 32'h0, 1'b1, 1);
        access("mis_half_st", 1, 1'b1, 32'h05, 3'b001, 32'h0000FFFF, 32'h0, 1'b1, 1);

        // both ports requesting continuously
        drive(0, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h04, 3'b010, 32'h0);
        g = 0; r = 0; dual = 0;
        for (int c = 0; c < 60 && r < 6; c++) begin
            @(negedge clk);
            if (g >= 6) begin
                drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
                drive(1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
            end
            #1;
            if (p0_gnt && p1_gnt) dual++;
            if (g < 6 && p0_gnt) begin order[g] = 0; g++; end
            else if (g < 6 && p1_gnt) begin order[g] = 1; g++; end
            if (p0_rvalid || p1_rvalid) begin
                rv_port = p1_rvalid ? 1 : 0;
                check("rr_rv_port", rv_port, (r < g) ? order[r] : -1);
                check("rr_rv_single", {31'b0, p0_rvalid && p1_rvalid}, 32'd0);
                // port 1 reads word 0x04, which the misaligned store must not have touched
                exp_rd = (rv_port == 0) ? 32'hDEADBEEF : 32'h0;
                check("rr_rdata", p0_rdata | p1_rdata, exp_rd);
                r++;
            end
        end
        check("rr_grants", g, 6);
        check("rr_responses", r, 6);
        check("rr_dual_gnt", dual, 0);
        for (int i = 0; i < 6; i++) check("rr_order", order[i], i % 2);

        // out-of-range load: memory reports the error
        access("oor_load", 0, 1'b0, 32'h400, 3'b010, 32'h0, 32'h0, 1'b1, 2);

        // reset during the access cycle of a store
        drive(0, 1'b1, 1'b1, 32'h20, 3'b010, 32'h12345678);
        g = 0;
        #1;
        while (!p0_gnt && g < 20) begin @(negedge clk); #1; g++; end
        check("rst_acc_gnt", {31'b0, p0_gnt}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        rst = 1'b1;
        #1;
        check("rst_acc_wen", {31'b0, mem_W_en}, 32'd0);
        @(negedge clk); #1;
        check_all_zero("rst_acc_after");
        rst = 1'b0;
        r = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (p0_rvalid || p1_rvalid) r++;
        end
        check("rst_acc_no_rv", r, 0);
        access("rst_acc_ld", 0, 1'b0, 32'h20, 3'b010, 32'h0, 32'h0, 1'b0, 2);

        check("no_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port data memory (`data_register`). It shares that memory between the core load/store unit (port 0) and a debug/DMA master (port 1) with round-robin arbitration. It registers each accepted request, drives exactly one memory access cycle and returns a registered response. Misaligned accesses are rejected before they reach the memory, which performs no alignment checking of its own.

## Interface
- `DATA_WIDTH`, 32: data width. Must match the memory.
- `clk`  in  1: single clock; everything is sampled on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `p0_req`, `p1_req`  in  1: access request. Held high until granted.
- `p0_we`, `p1_we`  in  1: 1 = store, 0 = load.
- `p0_addr`, `p1_addr`  in  32: byte address.
- `p0_rw_type`, `p1_rw_type`  in  3: `[1:0]` 00 = byte, 01 = half, 1x = word; `[2]` 1 = zero-extend, 0 = sign-extend.
- `p0_wdata`, `p1_wdata`  in  DATA_WIDTH: store data.
- `p0_gnt`, `p1_gnt`  out  1: combinational grant. The request is accepted on this cycle's edge.
- `p0_rvalid`, `p1_rvalid`  out  1: one-cycle response pulse. Asserted for loads and stores.
- `p0_rdata`, `p1_rdata`  out  DATA_WIDTH: load data, valid only with rvalid. 0 for stores and errors.
- `p0_err`, `p1_err`  out  1: valid with rvalid. Set on misalignment or when the memory reports an error.
- `mem_W_en`, `mem_R_en`  out  1: memory strobes.
- `mem_addr`  out  32: memory address.
- `mem_RW_type`  out  3: memory access type.
- `mem_din`  out  DATA_WIDTH: memory write data.
- `mem_dout`  in  DATA_WIDTH: memory read data (combinational).
- `mem_error`  in  1: memory error flag (combinational).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant is given only in IDLE, to at most one port.
  - If both ports request, the port not granted last wins. The priority pointer `last` resets to 1, so port 0 wins first.
  - A single requester always wins.
  - On a grant, these are latched: owner, we, addr, rw_type, wdata. `last` is set to the owner.
  - Misalignment is computed from the request: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Well-aligned request: go to ACCESS.
  - Misaligned request: latch err=1, skip ACCESS and go straight to RESP. No memory strobe is driven.
- ACCESS (exactly 1 cycle):
  - Drive `mem_addr`, `mem_RW_type` and `mem_din` from the latched values.
  - Drive `mem_W_en` = we & !rst and `mem_R_en` = !we.
  - On the edge, capture `rdata` = `mem_dout` if load and `mem_error`==0, else 0. Capture err = `mem_error`.
  - Go to RESP.
- RESP (1 cycle):
  - Assert the owner's rvalid with the captured rdata and err. The other port's outputs stay 0.
  - Go to IDLE.
- Outside ACCESS, `mem_W_en` = `mem_R_en` = 0. `mem_addr`, `mem_RW_type` and `mem_din` hold their latched values. The memory must never see `W_en` and `R_en` together.
- No requests are queued. A port that is not granted keeps `req` asserted. Dropping `req` before the grant is legal and has no effect.
- Responses are always returned in grant order. There is only ever one outstanding access.

## Timing
- Reset (synchronous, sampled on edge): state = IDLE, `last` = 1. All latched registers and all outputs are 0, including both gnt, rvalid, rdata and err and all mem_* strobes.
- `rst` high during ACCESS: `mem_W_en` is forced low, so no write commits. The response is dropped and no rvalid follows.
- `rst` high during RESP: rvalid is still visible combinationally that cycle. Requesters must ignore responses while `rst`=1.
- Latency from grant edge:
  - Aligned access: cycle G = grant, G+1 = ACCESS, G+2 = rvalid.
  - Misaligned access: rvalid at G+1.
- Throughput: one aligned access per 3 cycles. Back-to-back requests from one port are granted in the cycle after its rvalid.
- A store's data is in memory at the end of ACCESS. A load issued on the next grant observes it.
- Both ports requesting continuously get alternating grants: 0, 1, 0, 1, and so on.

## Test plan
- Reset, then assert `p0_req` with we=1, addr=0x10, word, wdata=0xDEADBEEF. Then issue a p0 load at 0x10, word. Required: the store gets rvalid at G+2 with err=0. The load returns rdata=0xDEADBEEF with err=0.
- After memory word 0x10 = 0xDEADBEEF, load byte 0x13, signed. Then load half 0x12, unsigned. Required: rdata=0xFFFFFFDE, then 0x0000DEAD.
- Both ports request continuously for 6 grants. Required: grant order 0, 1, 0, 1, 0, 1. Never two gnt in one cycle. Each rvalid goes to the correct port only.
- p1 issues a word load at 0x02, then a half store at 0x05. Required: rvalid at G+1 with err=1 and rdata=0. `mem_W_en` and `mem_R_en` are never asserted. Memory contents are unchanged.
- p0 issues a word load at 0x400, which is outside the depth (ADDR_WIDTH=8). Required: `mem_R_en` pulses once, rvalid at G+2 with err=1 and rdata=0.
- p0 issues a store of 0x12345678 to 0x20, and `rst` is pulsed during ACCESS. Required: no rvalid. All outputs are 0 the next cycle. A later load of 0x20 returns 0.
